jtag_tap_ctrl: RTL and testbench

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl.sv | 102 ++++++++++
 tb/tb_jtag_tap_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller clocked by clk, advanced by a synchronized TCK strobe (tck_en).
// Optional macro JTAG_TRST_EN adds a synchronous active-low trst_n acting like n_rst.
module jtag_tap_ctrl #(
  parameter int unsigned          IR_WIDTH = 4,
  parameter logic [IR_WIDTH-1:0]  IR_RESET = IR_WIDTH'(4'b0001)
) (
  input  logic                clk,
  input  logic                n_rst,
`ifdef JTAG_TRST_EN
  input  logic                trst_n,
`endif
  input  logic                tck_en,
  input  logic                tms,
  input  logic                tdi,
  output logic [3:0]          tap_state,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic [IR_WIDTH-1:0] ir,
  output logic                tdo_ir,
  output logic                tlr
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC, SELDR   = 4'h7, CAPDR   = 4'h6,
    SHDR    = 4'h2, EX1DR   = 4'h1, PAUSEDR = 4'h3, EX2DR   = 4'h0,
    UPDDR   = 4'h5, SELIR   = 4'h4, CAPIR   = 4'hE, SHIR    = 4'hA,
    EX1IR   = 4'h9, PAUSEIR = 4'hB, EX2IR   = 4'h8, UPDIR   = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] stage_q, stage_d;
  logic                reset_n;

`ifdef JTAG_TRST_EN
  assign reset_n = n_rst & trst_n;
`else
  assign reset_n = n_rst;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= TLR;
      ir_q    <= IR_RESET;
      stage_q <= '1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_en) begin
      case (state_q)
        TLR:     state_d = tms ? TLR     : RTI;
        RTI:     state_d = tms ? SELDR   : RTI;
        SELDR:   state_d = tms ? SELIR   : CAPDR;
        CAPDR:   state_d = tms ? EX1DR   : SHDR;
        SHDR:    state_d = tms ? EX1DR   : SHDR;
        EX1DR:   state_d = tms ? UPDDR   : PAUSEDR;
        PAUSEDR: state_d = tms ? EX2DR   : PAUSEDR;
        EX2DR:   state_d = tms ? UPDDR   : SHDR;
        UPDDR:   state_d = tms ? SELDR   : RTI;
        SELIR:   state_d = tms ? TLR     : CAPIR;
        CAPIR:   state_d = tms ? EX1IR   : SHIR;
        SHIR:    state_d = tms ? EX1IR   : SHIR;
        EX1IR:   state_d = tms ? UPDIR   : PAUSEIR;
        PAUSEIR: state_d = tms ? EX2IR   : PAUSEIR;
        EX2IR:   state_d = tms ? UPDIR   : SHIR;
        UPDIR:   state_d = tms ? SELDR   : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // IR actions key off the state being left on this strobe, not the one being entered.
  always_comb begin
    ir_d    = ir_q;
    stage_d = stage_q;
    if (tck_en) begin
      case (state_q)
        CAPIR:   stage_d = IR_WIDTH'(2'b01);
        SHIR:    stage_d = {tdi, stage_q[IR_WIDTH-1:1]};
        UPDIR:   ir_d    = stage_q;
        TLR:     ir_d    = IR_RESET;
        default: ;
      endcase
    end
  end

  assign tap_state  = state_q;
  assign capture_dr = reset_n & tck_en & (state_q == CAPDR);
  assign shift_dr   = reset_n & tck_en & (state_q == SHDR);
  assign update_dr  = reset_n & tck_en & (state_q == UPDDR);
  assign ir         = ir_q;
  assign tdo_ir     = stage_q[0];
  assign tlr        = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed vector table, multi-cycle sequences,
// and randomized stimulus against a name-based TAP reference model.
module tb_jtag_tap_ctrl;

  localparam logic [3:0] IR_RST = 4'b0001;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0, tck_en = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic       trst_n_tb = 1'b1;
  logic [3:0] tap_state, ir;
  logic       capture_dr, shift_dr, update_dr, tdo_ir, tlr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_tap_ctrl #(.IR_WIDTH(4), .IR_RESET(IR_RST)) dut (
    .clk(clk),
    .n_rst(n_rst),
`ifdef JTAG_TRST_EN
    .trst_n(trst_n_tb),
`endif
    .tck_en(tck_en),
    .tms(tms),
    .tdi(tdi),
    .tap_state(tap_state),
    .capture_dr(capture_dr),
    .shift_dr(shift_dr),
    .update_dr(update_dr),
    .ir(ir),
    .tdo_ir(tdo_ir),
    .tlr(tlr)
  );

  // Reference model: states by their standard names, transitions as lookup tables.
  string      nxt0[string];
  string      nxt1[string];
  logic [3:0] enc[string];
  string      m_st;
  logic [3:0] m_ir, m_stage;

  logic [2:0] s_pul;
  int         n_cap, n_sh, n_upd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add_st(input string n, input logic [3:0] code, input string on0, input string on1);
    enc[n]  = code;
    nxt0[n] = on0;
    nxt1[n] = on1;
  endtask

  task automatic step(input logic r, input logic e, input logic m, input logic d);
    logic r_eff;
    logic [2:0] exp_pul;
    @(negedge clk);
    n_rst = r; tck_en = e; tms = m; tdi = d;
    #1;
    r_eff = r;
`ifdef JTAG_TRST_EN
    r_eff = r & trst_n_tb;
`endif
    exp_pul = {r_eff && e && m_st == "CAPDR", r_eff && e && m_st == "SHDR",
               r_eff && e && m_st == "UPDDR"};
    s_pul = {capture_dr, shift_dr, update_dr};
    chk("model_pulses", {29'd0, s_pul}, {29'd0, exp_pul});
    n_cap += int'(capture_dr);
    n_sh  += int'(shift_dr);
    n_upd += int'(update_dr);
    if (!r_eff) begin
      m_st = "TLR"; m_ir = IR_RST; m_stage = 4'hF;
    end else if (e) begin
      if (m_st == "CAPIR")      m_stage = 4'd1;
      else if (m_st == "SHIR")  m_stage = (m_stage >> 1) | (4'(d) << 3);
      else if (m_st == "UPDIR") m_ir = m_stage;
      else if (m_st == "TLR")   m_ir = IR_RST;
      m_st = m ? nxt1[m_st] : nxt0[m_st];
    end
    @(posedge clk);
    #1;
    chk("model_state", {28'd0, tap_state}, {28'd0, enc[m_st]});
    chk("model_ir",    {28'd0, ir},        {28'd0, m_ir});
    chk("model_tdo",   {31'd0, tdo_ir},    {31'd0, m_stage[0]});
    chk("model_tlr",   {31'd0, tlr},       {31'd0, 1'(m_st == "TLR")});
  endtask

  typedef struct packed {
    logic       r, e, m, d;
    logic [2:0] pul;
    logic [3:0] st;
    logic [3:0] ir;
    logic       tdo;
  } vec_t;

  function automatic vec_t mk(input logic r, e, m, d, input logic [2:0] pul,
                              input logic [3:0] st, input logic [3:0] irv, input logic tdo);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.d = d; v.pul = pul; v.st = st; v.ir = irv; v.tdo = tdo;
    return v;
  endfunction

  vec_t tv[14];

  initial begin
    add_st("TLR",     4'hF, "RTI",     "TLR");
    add_st("RTI",     4'hC, "RTI",     "SELDR");
    add_st("SELDR",   4'h7, "CAPDR",   "SELIR");
    add_st("CAPDR",   4'h6, "SHDR",    "EX1DR");
    add_st("SHDR",    4'h2, "SHDR",    "EX1DR");
    add_st("EX1DR",   4'h1, "PAUSEDR", "UPDDR");
    add_st("PAUSEDR", 4'h3, "PAUSEDR", "EX2DR");
    add_st("EX2DR",   4'h0, "SHDR",    "UPDDR");
    add_st("UPDDR",   4'h5, "RTI",     "SELDR");
    add_st("SELIR",   4'h4, "CAPIR",   "TLR");
    add_st("CAPIR",   4'hE, "SHIR",    "EX1IR");
    add_st("SHIR",    4'hA, "SHIR",    "EX1IR");
    add_st("EX1IR",   4'h9, "PAUSEIR", "UPDIR");
    add_st("PAUSEIR", 4'hB, "PAUSEIR", "EX2IR");
    add_st("EX2IR",   4'h8, "SHIR",    "UPDIR");
    add_st("UPDIR",   4'hD, "RTI",     "SELDR");
    m_st = "TLR"; m_ir = IR_RST; m_stage = 4'hF;
    n_cap = 0; n_sh = 0; n_upd = 0;

    // Reset, walk to Shift-IR, shift 0,1,0,1, update: ir becomes 1010.
    tv[0]  = mk(0, 0, 0, 0, 3'b000, 4'hF, 4'h1, 1);
    tv[1]  = mk(1, 1, 0, 0, 3'b000, 4'hC, 4'h1, 1);
    tv[2]  = mk(1, 0, 1, 0, 3'b000, 4'hC, 4'h1, 1);
    tv[3]  = mk(1, 1, 1, 0, 3'b000, 4'h7, 4'h1, 1);
    tv[4]  = mk(1, 1, 1, 0, 3'b000, 4'h4, 4'h1, 1);
    tv[5]  = mk(1, 1, 0, 0, 3'b000, 4'hE, 4'h1, 1);
    tv[6]  = mk(1, 1, 0, 0, 3'b000, 4'hA, 4'h1, 1);
    tv[7]  = mk(1, 1, 0, 0, 3'b000, 4'hA, 4'h1, 0);
    tv[8]  = mk(1, 1, 0, 1, 3'b000, 4'hA, 4'h1, 0);
    tv[9]  = mk(1, 1, 0, 0, 3'b000, 4'hA, 4'h1, 0);
    tv[10] = mk(1, 1, 1, 1, 3'b000, 4'h9, 4'h1, 0);
    tv[11] = mk(1, 0, 0, 0, 3'b000, 4'h9, 4'h1, 0);
    tv[12] = mk(1, 1, 1, 0, 3'b000, 4'hD, 4'h1, 0);
    tv[13] = mk(1, 1, 0, 0, 3'b000, 4'hC, 4'hA, 0);

    for (int i = 0; i < 14; i++) begin
      step(tv[i].r, tv[i].e, tv[i].m, tv[i].d);
      chk($sformatf("vec%0d_pulses", i), {29'd0, s_pul}, {29'd0, tv[i].pul});
      chk($sformatf("vec%0d_state", i), {28'd0, tap_state}, {28'd0, tv[i].st});
      chk($sformatf("vec%0d_ir", i), {28'd0, ir}, {28'd0, tv[i].ir});
      chk($sformatf("vec%0d_tdo", i), {31'd0, tdo_ir}, {31'd0, tv[i].tdo});
      chk($sformatf("vec%0d_tlr", i), {31'd0, tlr}, {31'd0, 1'(tv[i].st == 4'hF)});
    end

    // DR scan with 3-clk gaps between strobes.
    n_cap = 0; n_sh = 0; n_upd = 0;
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 3; g++) step(1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
      step(1, 1, 0, $urandom_range(0, 1));
    end
    chk("dr_capture_count", n_cap, 1);
    chk("dr_shift_count", n_sh, 8);
    chk("dr_update_count", n_upd, 0);
    chk("dr_state_shdr", {28'd0, tap_state}, 32'h2);

    // Five TMS=1 strobes from Shift-DR reach TLR through Update-DR.
    n_upd = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
    chk("tms5_state_tlr", {28'd0, tap_state}, 32'hF);
    chk("tms5_update_once", n_upd, 1);
    step(1, 1, 1, 0);
    chk("tms5_ir_reset", {28'd0, ir}, {28'd0, IR_RST});

    // Reset during Shift-IR after two shifts.
    n_upd = 0;
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("midshir_state", {28'd0, tap_state}, 32'hA);
    step(0, 1, 0, 0);
    chk("rst_pulses_zero", {29'd0, s_pul}, 32'd0);
    chk("midshir_rst_state", {28'd0, tap_state}, 32'hF);
    chk("midshir_rst_ir", {28'd0, ir}, {28'd0, IR_RST});
    chk("midshir_rst_tdo", {31'd0, tdo_ir}, 32'd1);
    chk("midshir_no_update", n_upd, 0);

`ifdef JTAG_TRST_EN
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    chk("trst_pausedr", {28'd0, tap_state}, 32'h3);
    trst_n_tb = 1'b0;
    step(1, 1, 1, 0);
    trst_n_tb = 1'b1;
    chk("trst_state_tlr", {28'd0, tap_state}, 32'hF);
    chk("trst_ir", {28'd0, ir}, {28'd0, IR_RST});
`endif

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
